// File: rtl/or1200_enc_mchan_engine.sv
// Multi-channel seed-driven keystream engine: each channel queues seeds, mixes a
// 32-bit pad over ROUNDS cycles and masks its data path while the pad is held.
module or1200_enc_mchan_engine #(
  parameter int          NCH    = 2,
  parameter int          DEPTH  = 4,
  parameter int          ROUNDS = 4,
  parameter logic [127:0] KEY   = 128'h0123456789abcdef0123456789abcdef,
  localparam int         CHW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               seed_valid,
  input  logic [CHW-1:0]     seed_ch,
  input  logic [31:0]        seedIn,
  input  logic [4:0]         seedAddr,
  input  logic [10:0]        seedImm,
  output logic               seed_ready,
  input  logic [NCH-1:0]     data_ack,
  input  logic [32*NCH-1:0]  dataIn,
  output logic [32*NCH-1:0]  dataOut,
  output logic [NCH-1:0]     unstall,
  output logic               seed_err
);
  localparam int             PW       = $clog2(DEPTH);
  localparam int             CW       = $clog2(DEPTH + 1);
  localparam int             NSLOT    = 1 << CHW;
  localparam logic [CHW:0]   NCH_W    = (CHW + 1)'(NCH);
  localparam logic [4:0]     LAST_RND = 5'(ROUNDS - 1);
  localparam logic [CW-1:0]  FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_MIX, ST_READY} state_t;

  logic             w_ch_ok;
  logic [NSLOT-1:0] w_full;
  logic [47:0]      w_entry;
  logic             r_seed_err;

  function automatic logic [31:0] key_word(input logic [1:0] idx);
    return KEY[{idx, 5'b0} +: 32];
  endfunction

  assign w_ch_ok    = ({1'b0, seed_ch} < NCH_W);
  assign w_entry    = {seedIn, seedAddr, seedImm};
  // Pushes to a nonexistent channel are swallowed, so the port never stalls on them.
  assign seed_ready = w_ch_ok ? ~w_full[seed_ch] : 1'b1;
  assign seed_err   = r_seed_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_seed_err <= 1'b0;
    else if (seed_valid && !w_ch_ok)
      r_seed_err <= 1'b1;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [47:0]   r_mem [DEPTH];
      logic [PW-1:0] r_wp;
      logic [PW-1:0] r_rp;
      logic [CW-1:0] r_cnt;
      state_t        r_st;
      state_t        w_st_next;
      logic [31:0]   r_s;
      logic [31:0]   r_pad;
      logic [4:0]    r_rnd;
      logic [31:0]   w_mix;
      logic [31:0]   w_load;
      logic [47:0]   w_head;
      logic          w_push;
      logic          w_pop;

      assign w_full[gi] = (r_cnt == FULL_CNT);
      assign w_push     = seed_valid & w_ch_ok & (seed_ch == CHW'(gi)) & ~w_full[gi];
      assign w_head     = r_mem[r_rp];
      assign w_load     = w_head[47:16] ^ {w_head[15:0], 16'h0} ^ key_word(2'd0);
      assign w_mix      = ({r_s[26:0], r_s[31:27]} ^ key_word(r_rnd[1:0])) + {27'b0, r_rnd};

      // An ack with a queued seed reloads straight into MIX, skipping IDLE.
      always_comb begin
        w_st_next = r_st;
        w_pop     = 1'b0;
        case (r_st)
          ST_IDLE: begin
            if (r_cnt != '0) begin
              w_pop     = 1'b1;
              w_st_next = ST_MIX;
            end
          end
          ST_MIX: begin
            if (r_rnd == LAST_RND)
              w_st_next = ST_READY;
          end
          ST_READY: begin
            if (data_ack[gi]) begin
              if (r_cnt != '0) begin
                w_pop     = 1'b1;
                w_st_next = ST_MIX;
              end else begin
                w_st_next = ST_IDLE;
              end
            end
          end
          default: w_st_next = ST_IDLE;
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_st  <= ST_IDLE;
          r_wp  <= '0;
          r_rp  <= '0;
          r_cnt <= '0;
          r_s   <= '0;
          r_rnd <= '0;
          r_pad <= '0;
        end else begin
          r_st <= w_st_next;
          if (w_push)
            r_wp <= r_wp + PW'(1);
          if (w_pop)
            r_rp <= r_rp + PW'(1);
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: ;
          endcase
          if (w_pop) begin
            r_s   <= w_load;
            r_rnd <= '0;
          end else if (r_st == ST_MIX) begin
            r_s   <= w_mix;
            r_rnd <= r_rnd + 5'd1;
            if (r_rnd == LAST_RND)
              r_pad <= w_mix;
          end
        end
      end

      // Storage needs no reset: pointers and count define which entries are live.
      always_ff @(posedge clk) begin
        if (w_push)
          r_mem[r_wp] <= w_entry;
      end

      assign unstall[gi]          = (r_st == ST_READY);
      assign dataOut[32*gi +: 32] = (r_st == ST_READY) ? (dataIn[32*gi +: 32] ^ r_pad) : 32'h0;
    end

    for (gi = NCH; gi < NSLOT; gi++) begin : g_unused_slot
      assign w_full[gi] = 1'b0;
    end
  endgenerate
endmodule

// File: tb/tb_or1200_enc_mchan_engine.sv
// Bench for or1200_enc_mchan_engine: a queue-and-countdown reference model checked
// every cycle, plus directed scenarios with hand-computed pads and latencies.
module tb_or1200_enc_mchan_engine;
  localparam int           NCH    = 3;
  localparam int           DEPTH  = 4;
  localparam int           ROUNDS = 4;
  localparam int           CHW    = 2;
  localparam logic [127:0] KEY    = 128'h0123456789abcdef0123456789abcdef;

  logic              clk;
  logic              rst;
  logic              seed_valid;
  logic [CHW-1:0]    seed_ch;
  logic [31:0]       seedIn;
  logic [4:0]        seedAddr;
  logic [10:0]       seedImm;
  logic              seed_ready;
  logic [NCH-1:0]    data_ack;
  logic [32*NCH-1:0] dataIn;
  logic [32*NCH-1:0] dataOut;
  logic [NCH-1:0]    unstall;
  logic              seed_err;

  or1200_enc_mchan_engine #(
    .NCH(NCH), .DEPTH(DEPTH), .ROUNDS(ROUNDS), .KEY(KEY)
  ) dut (
    .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_ch(seed_ch),
    .seedIn(seedIn), .seedAddr(seedAddr), .seedImm(seedImm), .seed_ready(seed_ready),
    .data_ack(data_ack), .dataIn(dataIn), .dataOut(dataOut), .unstall(unstall),
    .seed_err(seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] kw(input int j);
    return KEY[32*(j % 4) +: 32];
  endfunction

  // Pad from a seed entry, straight from the mixing rule.
  function automatic logic [31:0] model_pad(input logic [47:0] e, input int rounds);
    logic [31:0] s;
    s = e[47:16] ^ {e[15:0], 16'h0} ^ kw(0);
    for (int r = 0; r < rounds; r++)
      s = (((s << 5) | (s >> 27)) ^ kw(r)) + 32'(r);
    return s;
  endfunction

  // Reference model: a seed queue per channel, a countdown of cycles until the pad
  // is available, and a held pad that stays until acknowledged.
  logic [47:0]       mq [NCH][DEPTH];
  int                mh [NCH];
  int                mc [NCH];
  int                mbusy [NCH];
  bit                mvalid [NCH];
  logic [31:0]       mpad [NCH];
  logic [31:0]       mnext [NCH];
  bit                merr;
  int                m_chi;
  bit                m_acc;
  bit                m_take;
  logic [NCH-1:0]    exp_un;
  logic [32*NCH-1:0] exp_do;
  logic              exp_rdy;

  always @(posedge clk) begin
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) begin
        mh[ch] = 0; mc[ch] = 0; mbusy[ch] = 0; mvalid[ch] = 0; mpad[ch] = '0; mnext[ch] = '0;
      end
      merr = 0;
    end else begin
      m_chi = int'(seed_ch);
      m_acc = 0;
      if (seed_valid) begin
        if (m_chi >= NCH) merr = 1;
        else if (mc[m_chi] < DEPTH) m_acc = 1;
      end
      for (int ch = 0; ch < NCH; ch++) begin
        m_take = 0;
        if (mvalid[ch]) begin
          if (data_ack[ch]) begin
            mvalid[ch] = 0;
            m_take = (mc[ch] > 0);
          end
        end else if (mbusy[ch] > 0) begin
          mbusy[ch]--;
          if (mbusy[ch] == 0) begin
            mvalid[ch] = 1;
            mpad[ch] = mnext[ch];
          end
        end else begin
          m_take = (mc[ch] > 0);
        end
        if (m_take) begin
          mnext[ch] = model_pad(mq[ch][mh[ch]], ROUNDS);
          mh[ch] = (mh[ch] + 1) % DEPTH;
          mc[ch]--;
          mbusy[ch] = ROUNDS;
        end
      end
      if (m_acc) begin
        mq[m_chi][(mh[m_chi] + mc[m_chi]) % DEPTH] = {seedIn, seedAddr, seedImm};
        mc[m_chi]++;
      end
    end
    #1;
    exp_un = '0;
    exp_do = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      exp_un[ch] = mvalid[ch];
      if (mvalid[ch]) exp_do[32*ch +: 32] = dataIn[32*ch +: 32] ^ mpad[ch];
    end
    exp_rdy = (int'(seed_ch) < NCH) ? (mc[int'(seed_ch)] < DEPTH) : 1'b1;
    check("cyc_unstall", unstall, exp_un);
    check("cyc_dataOut", dataOut, exp_do);
    check("cyc_seed_ready", seed_ready, exp_rdy);
    check("cyc_seed_err", seed_err, merr);
  end

  // Called at a negedge; presents one push for the next rising edge.
  task automatic push(input int ch, input logic [31:0] d, input logic [4:0] a, input logic [10:0] im);
    seed_valid = 1'b1; seed_ch = CHW'(ch); seedIn = d; seedAddr = a; seedImm = im;
    $display("push ch=%0d seedIn=%h seedAddr=%h seedImm=%h ready=%b", ch, d, a, im, seed_ready);
    @(negedge clk);
    seed_valid = 1'b0;
  endtask

  task automatic ack(input int ch);
    $display("ack  ch=%0d dataIn=%h dataOut=%h", ch, dataIn[32*ch +: 32], dataOut[32*ch +: 32]);
    data_ack[ch] = 1'b1;
    @(negedge clk);
    data_ack[ch] = 1'b0;
  endtask

  task automatic wait_up(input int ch, input int maxc, output int c);
    c = 0;
    while (!unstall[ch] && c < maxc) begin
      @(negedge clk);
      c++;
    end
    if (!unstall[ch]) check("wait_unstall_timeout", unstall[ch], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  int c;

  initial begin
    rst = 1'b0; seed_valid = 1'b0; seed_ch = '0; seedIn = '0; seedAddr = '0; seedImm = '0;
    data_ack = '0; dataIn = '0;

    check("model_pin_r1", model_pad(48'h0, 1), 32'hBCD2701E);
    check("model_pin_r4", model_pad(48'h0, 4), 32'h81403EBE);

    repeat (2) @(negedge clk);
    check("rst_unstall", unstall, 0);
    check("rst_dataOut", dataOut, 0);
    check("rst_seed_ready", seed_ready, 1);
    check("rst_seed_err", seed_err, 0);
    rst = 1'b1;
    @(negedge clk);

    // Zero seed on ch0: latency ROUNDS+1 edges and the known pad.
    push(0, 32'h0, 5'h0, 11'h0);
    wait_up(0, 20, c);
    check("lat_ch0", c, ROUNDS + 1);
    check("pad_zero", dataOut[31:0], 32'h81403EBE);
    dataIn[31:0] = 32'h81403EBE;
    #1 check("unmask_zero", dataOut[31:0], 32'h0);
    dataIn[31:0] = 32'hFFFFFFFF;
    #1 check("mask_ones", dataOut[31:0], 32'h7EBFC141);
    ack(0);

    // Fill ch1: one seed goes into MIX, four queue, the sixth sees a full FIFO.
    for (int k = 0; k < 5; k++)
      push(1, 32'h1000_0000 * (k + 1) + 32'(k * 7), 5'(k + 3), 11'(k * 100 + 5));
    seed_valid = 1'b1; seed_ch = 2'd1; seedIn = 32'hDEAD_BEEF; seedAddr = 5'h1F; seedImm = 11'h7FF;
    #1 check("full_ready", seed_ready, 0);
    @(negedge clk);
    seed_valid = 1'b0;
    dataIn[63:32] = 32'hA5A5_5A5A;
    for (int p = 0; p < 5; p++) begin
      wait_up(1, 30, c);
      if (p > 0) check("b2b_gap", c, ROUNDS);
      ack(1);
    end
    repeat (3) @(negedge clk);
    check("ch1_idle", unstall[1], 0);

    // Out-of-range channel: sticky error, port stays ready.
    seed_valid = 1'b1; seed_ch = 2'd3; seedIn = 32'h1234_5678;
    #1 check("bad_ready", seed_ready, 1);
    @(negedge clk);
    seed_valid = 1'b0;
    check("err_set", seed_err, 1);
    repeat (5) @(negedge clk);
    check("err_sticky", seed_err, 1);

    // Concurrent channels with simultaneous acks.
    push(0, 32'hCAFE_F00D, 5'h0A, 11'h123);
    push(2, 32'h0BAD_C0DE, 5'h15, 11'h456);
    push(0, 32'h1357_9BDF, 5'h11, 11'h0F0);
    dataIn = {$urandom, $urandom, $urandom};
    c = 0;
    while (!(unstall[0] && unstall[2]) && c < 30) begin
      @(negedge clk);
      c++;
    end
    check("both_ready", {unstall[2], unstall[0]}, 2'b11);
    $display("ack  ch=0,2 dataOut=%h", dataOut);
    data_ack = 3'b101;
    @(negedge clk);
    data_ack = '0;
    dataIn = {$urandom, $urandom, $urandom};
    wait_up(0, 30, c);
    check("ch0_second_gap", c, ROUNDS);
    ack(0);

    // ch0 parked in READY, ch2 two cycles into MIX with three seeds queued, then reset.
    push(0, 32'h0, 5'h0, 11'h0);
    wait_up(0, 20, c);
    push(2, 32'h1111_1111, 5'h01, 11'h001);
    push(2, 32'h2222_2222, 5'h02, 11'h002);
    push(2, 32'h3333_3333, 5'h03, 11'h003);
    push(2, 32'h4444_4444, 5'h04, 11'h004);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_unstall", unstall, 0);
    check("mid_rst_dataOut", dataOut, 0);
    check("mid_rst_seed_err", seed_err, 0);
    check("mid_rst_seed_ready", seed_ready, 1);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_quiet", unstall, 0);
    dataIn = '0;
    push(2, 32'h0, 5'h0, 11'h0);
    wait_up(2, 20, c);
    check("post_rst_lat", c, ROUNDS + 1);
    check("post_rst_pad", dataOut[95:64], 32'h81403EBE);
    ack(2);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
